// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner.
//   - state_t      : FSM state encoding (IDLE, RUN, DONE)
//   - DEF_N_IN     : default evaluator input count
//   - DEF_SETTLE   : default settle time in cycles
//   - MAXTERM4_TT  : golden table of (~c|d)&(c|~d)&(b|c|d), bit i = vector i
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_SETTLE = 1;

  localparam logic [15:0] MAXTERM4_TT = 16'h9898;

endpackage

// File: rtl/maxterm4_eval.sv
// Combinational 4-input maxterm function: y = (~c|d)&(c|~d)&(b|c|d).
// Ports:
//   a, b, c, d : function inputs ({a,b,c,d} = vector[3:0])
//   y          : function result
module maxterm4_eval (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);

  logic unused_a;
  assign unused_a = a;  // a does not appear in this particular function

  assign y = (~c | d) & (c | ~d) & (b | c | d);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of an external combinational evaluator, holds
// each for SETTLE cycles, samples the 1-bit result, builds the truth table
// and compares it against an expected table latched at start.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a sweep (IDLE only)
//   abort          : cancel a sweep (RUN only)
//   expected       : expected table, latched at accepted start
//   vec_out        : vector driven to the evaluator
//   eval_in        : evaluator result for vec_out
//   busy           : high in RUN or DONE
//   done           : one-cycle completion pulse
//   table_out      : captured results, bit i = vector i
//   match          : table_out equals latched expected (valid from done)
//   mismatch_count : number of differing bits, 0..T
//   first_fail     : lowest failing vector index, 0 if none
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [(2**N_IN)-1:0]  expected,
  output logic [N_IN-1:0]       vec_out,
  input  logic                  eval_in,
  output logic                  busy,
  output logic                  done,
  output logic [(2**N_IN)-1:0]  table_out,
  output logic                  match,
  output logic [N_IN:0]         mismatch_count,
  output logic [N_IN-1:0]       first_fail
);

  localparam int T  = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   LAST_WAIT = CW'(SETTLE - 1);
  // Completion is detected on the last index, never on counter overflow.
  localparam logic [N_IN-1:0] LAST_IDX  = '1;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [T-1:0]    exp_q;
  logic            sample_fail;

  // vec_out doubles as the sweep index.
  assign sample_fail = (eval_in != exp_q[vec_out]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      exp_q          <= '0;
      vec_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      table_out      <= '0;
      match          <= 1'b0;
      mismatch_count <= '0;
      first_fail     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees
      // the value from before this edge regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            vec_out        <= '0;
            wait_cnt       <= '0;
            exp_q          <= expected;
            table_out      <= '0;
            match          <= 1'b0;
            mismatch_count <= '0;
            first_fail     <= '0;
          end
        end

        RUN: begin
          if (abort) begin
            // Abort wins over a sample on the same edge; partial results stay.
            state <= IDLE;
            busy  <= 1'b0;
            match <= 1'b0;
          end else if (wait_cnt == LAST_WAIT) begin
            table_out[vec_out] <= eval_in;
            if (sample_fail) begin
              mismatch_count <= mismatch_count + 1'b1;
              if (mismatch_count == '0) first_fail <= vec_out;
            end
            if (vec_out == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
              // Include the final sample, whose count update lands this edge.
              match <= (mismatch_count == '0) && !sample_fail;
            end else begin
              vec_out  <= vec_out + 1'b1;
              wait_cnt <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
